count_updn_mod: RTL and testbench

COUNT_UPDN_MOD -- requirements
Module: count_updn_mod

---
 rtl/count_pkg.sv | 7 +
 rtl/count_presc.sv | 28 ++
 rtl/count_updn_mod.sv | 65 ++++++
 tb/tb_count_updn_mod.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared mode type, direction constants and prescaler limit for count_updn_mod.
package count_pkg;
  typedef enum logic {CNT_WRAP, CNT_SAT} count_mode_e;
  localparam int PRESC_MAX = 256;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/count_presc.sv
// count_presc: enable-gated tick divider; the counter vanishes when PRESC is 1.
module count_presc #(
  parameter int PRESC = 1
) (
  input  logic clk5m,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  generate
    if (PRESC == 1) begin : g_none
      logic unused_ok;
      assign unused_ok = clk5m ^ rst;
      assign tick = en && !clr;
    end else begin : g_div
      localparam int PW = $clog2(PRESC);
      localparam logic [PW-1:0] LAST = PW'(PRESC - 1);
      logic [PW-1:0] presc_cnt;
      always_ff @(posedge clk5m or posedge rst) begin
        if (rst) presc_cnt <= '0;
        else if (clr) presc_cnt <= '0;
        else if (en) presc_cnt <= (presc_cnt == LAST) ? '0 : presc_cnt + 1'b1;
      end
      assign tick = en && !clr && presc_cnt == LAST;
    end
  endgenerate
endmodule

// File: rtl/count_updn_mod.sv
// count_updn_mod: loadable up/down counter with ceiling, prescaler and terminal-count pulse.
// Define COUNT_SAT_EN to add the sat port and saturating mode; otherwise it always wraps.
module count_updn_mod
  import count_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int MAX_VAL = 1023,
  parameter int PRESC   = 1
) (
  input  logic             clk5m,
  input  logic             rst,
  input  logic             en,
  input  logic             updn,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
`ifdef COUNT_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             zero
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam int P = (PRESC > PRESC_MAX) ? PRESC_MAX : PRESC;
  count_mode_e mode;
  logic tick, bound, hit, tc_nxt;
  logic [WIDTH:0] stepv;
  logic [WIDTH-1:0] nxt, clamp;
`ifdef COUNT_SAT_EN
  assign mode = sat ? CNT_SAT : CNT_WRAP;
`else
  assign mode = CNT_WRAP;
`endif
  count_presc #(.PRESC(P)) u_presc (
    .clk5m(clk5m),
    .rst(rst),
    .en(en),
    .clr(load),
    .tick(tick)
  );
  // bound: the step would cross the range edge; hit: the step lands on it
  always_comb begin
    stepv = (updn == DIR_DN) ? {1'b0, cnt} - 1'b1 : {1'b0, cnt} + 1'b1;
    bound = (updn == DIR_DN) ? cnt == '0 : cnt == MAXV;
    hit = (updn == DIR_UP) ? stepv == {1'b0, MAXV} : stepv == '0;
    nxt = !bound ? stepv[WIDTH-1:0] : (mode == CNT_SAT) ? cnt : (updn == DIR_DN) ? MAXV : '0;
    tc_nxt = (mode == CNT_SAT) ? !bound && hit : bound;
    clamp = (data_in > MAXV) ? MAXV : data_in;
  end
  always_ff @(posedge clk5m or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tc <= 1'b0;
    end else if (load) begin
      cnt <= clamp;
      tc <= 1'b0;
    end else if (tick) begin
      cnt <= nxt;
      tc <= tc_nxt;
    end else begin
      tc <= 1'b0;
    end
  end
  assign zero = cnt == '0;
endmodule

// File: tb/tb_count_updn_mod.sv
// tb_count_updn_mod: random and directed checks of count_updn_mod (PRESC 1 and 4) against an arithmetic model.
module tb_count_updn_mod;
  localparam int W = 10;
  localparam int MX = 1000;
  logic clk5m = 1'b0;
  logic rst = 1'b1, en = 1'b0, updn = 1'b0, load = 1'b0, sat = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] cnt1, cnt4;
  logic tc1, tc4, zero1, zero4;
  int n_chk = 0, n_fail = 0;
  int m_cnt[2], m_tc[2], m_pc[2];
  int pr[2] = '{1, 4};
  int sat_eff;

  always #5 clk5m = ~clk5m;

  count_updn_mod #(.WIDTH(W), .MAX_VAL(MX), .PRESC(1)) dut1 (
    .clk5m(clk5m), .rst(rst), .en(en), .updn(updn), .load(load), .data_in(data_in),
`ifdef COUNT_SAT_EN
    .sat(sat),
`endif
    .cnt(cnt1), .tc(tc1), .zero(zero1)
  );
  count_updn_mod #(.WIDTH(W), .MAX_VAL(MX), .PRESC(4)) dut4 (
    .clk5m(clk5m), .rst(rst), .en(en), .updn(updn), .load(load), .data_in(data_in),
`ifdef COUNT_SAT_EN
    .sat(sat),
`endif
    .cnt(cnt4), .tc(tc4), .zero(zero4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_tc[k] = 0;
      m_pc[k] = 0;
    end
  endtask

  task automatic model();
    int o, n, s;
`ifdef COUNT_SAT_EN
    s = int'(sat);
`else
    s = 0;
`endif
    sat_eff = s;
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        m_cnt[k] = (int'(data_in) > MX) ? MX : int'(data_in);
        m_pc[k] = 0;
        m_tc[k] = 0;
      end else if (en && m_pc[k] == pr[k] - 1) begin
        m_pc[k] = 0;
        o = m_cnt[k];
        if (!updn) n = s ? ((o < MX) ? o + 1 : MX) : (o + 1) % (MX + 1);
        else n = s ? ((o > 0) ? o - 1 : 0) : (o + MX) % (MX + 1);
        m_tc[k] = s ? int'(n != o && (n == 0 || n == MX)) : int'(!updn ? o == MX : o == 0);
        m_cnt[k] = n;
      end else begin
        if (en) m_pc[k] = m_pc[k] + 1;
        m_tc[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("cnt1", int'(cnt1), m_cnt[0]);
    chk("tc1", int'(tc1), m_tc[0]);
    chk("zero1", int'(zero1), int'(m_cnt[0] == 0));
    chk("cnt4", int'(cnt4), m_cnt[1]);
    chk("tc4", int'(tc4), m_tc[1]);
    chk("zero4", int'(zero4), int'(m_cnt[1] == 0));
  endtask

  task automatic cyc();
    @(posedge clk5m);
    model();
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #3 rst = 1'b1;
    mreset();
    #1;
    chk("rst_cnt1", int'(cnt1), 0);
    chk("rst_tc1", int'(tc1), 0);
    chk("rst_cnt4", int'(cnt4), 0);
    chk("rst_zero1", int'(zero1), 1);
    #1 rst = 1'b0;
  endtask

  initial begin
    int tcs;
    int pick;
    mreset();
    #12;
    chk("reset_cnt", int'(cnt1), 0);
    chk("reset_tc", int'(tc1), 0);
    chk("reset_zero", int'(zero1), 1);
    rst = 1'b0;
    en = 1'b1;
    updn = 1'b0;
    repeat (10) cyc();
    chk("up10", int'(cnt1), 10);
    updn = 1'b1;
    repeat (5) cyc();
    chk("dn5", int'(cnt1), 5);
    chk("dn5_zero", int'(zero1), 0);
    load = 1'b1;
    data_in = 10'd999;
    updn = 1'b0;
    cyc();
    load = 1'b0;
    cyc();
    chk("at_max", int'(cnt1), 1000);
    cyc();
    chk("wrap_cnt", int'(cnt1), 0);
    chk("wrap_tc", int'(tc1), 1);
    chk("wrap_zero", int'(zero1), 1);
    cyc();
    chk("wrap_tc_once", int'(tc1), 0);
    load = 1'b1;
    data_in = 10'd1023;
    cyc();
    load = 1'b0;
    chk("clamp", int'(cnt1), 1000);
    en = 1'b0;
    repeat (5) cyc();
    chk("hold", int'(cnt1), 1000);
`ifdef COUNT_SAT_EN
    load = 1'b1;
    data_in = 10'd1;
    cyc();
    load = 1'b0;
    sat = 1'b1;
    updn = 1'b1;
    en = 1'b1;
    tcs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sat_cnt", int'(cnt1), 0);
      tcs += int'(tc1);
    end
    chk("sat_tc_count", tcs, 1);
    sat = 1'b0;
`endif
    load = 1'b1;
    data_in = '0;
    en = 1'b1;
    updn = 1'b0;
    cyc();
    load = 1'b0;
    repeat (8) cyc();
    chk("presc8", int'(cnt4), 2);
    en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    repeat (4) cyc();
    chk("presc_resume", int'(cnt4), 3);
    load = 1'b1;
    data_in = 10'd7;
    cyc();
    load = 1'b0;
    chk("pre_rst", int'(cnt1), 7);
    mid_reset();
    cyc();
    chk("post_rst_step", int'(cnt1), 1);
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      updn = $urandom_range(0, 1) == 1;
      sat = $urandom_range(0, 1) == 1;
      load = ($urandom_range(0, 15) == 0);
      pick = $urandom_range(0, 5);
      data_in = (pick == 0) ? 10'd0 : (pick == 1) ? 10'd1 : (pick == 2) ? 10'd999 :
                (pick == 3) ? 10'd1000 : (pick == 4) ? 10'd1023 : W'($urandom);
      if ($urandom_range(0, 79) == 0) mid_reset();
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
